// File: rtl/scan_pkg.sv
// Shared types and default widths for the scanline delay sequencer and its element trackers.
package scan_pkg;

    localparam int DW_INTEGER_DEF  = 16;
    localparam int DW_FRACTION_DEF = 8;
    localparam int DW_DELAY_DEF    = 12;
    localparam int TERM_W          = DW_INTEGER_DEF + DW_FRACTION_DEF - 3;
    localparam int FRAC_OUT        = DW_FRACTION_DEF - 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CONFIG     = 3'd1,
        WAIT_TERMS = 3'd2,
        UPDATE     = 3'd3,
        PRESENT    = 3'd4,
        DONE       = 3'd5
    } state_t;

    typedef logic signed [TERM_W-1:0] term_t;
    typedef logic [DW_DELAY_DEF-1:0]  delay_t;

endpackage

// File: rtl/element_delay_tracker.sv
// One transducer element: accumulates comparator terms and advances the sample delay
// whenever the accumulator reaches the (2*delay+1) threshold.
module element_delay_tracker #(
    parameter int TERM_W   = 21,
    parameter int DELAY_W  = 12,
    parameter int FRAC_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     update,
    input  logic signed [TERM_W-1:0] term,
    output logic [DELAY_W-1:0]       delay,
    output logic                     sat
);

    localparam int ACC_W = TERM_W + 2;
    localparam int PAD_W = ACC_W - DELAY_W - 1 - FRAC_OUT;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum, th;
    logic signed [ACC_W:0]   sum_wide;
    logic [DELAY_W-1:0]      delay_q, delay_d;

    always_comb begin
        acc_d    = acc_q;
        delay_d  = delay_q;
        sat      = 1'b0;
        sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(term);
        // Clamp instead of wrapping so a long run of negative terms cannot flip sign.
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum = {sum_wide[ACC_W], {(ACC_W-1){~sum_wide[ACC_W]}}};
        end else begin
            sum = sum_wide[ACC_W-1:0];
        end
        th = $signed({{PAD_W{1'b0}}, delay_q, 1'b1, {FRAC_OUT{1'b0}}});
        if (clear) begin
            acc_d   = '0;
            delay_d = '0;
        end else if (update) begin
            if (sum >= th) begin
                acc_d = sum - th;
                if (&delay_q) begin
                    sat = 1'b1;
                end else begin
                    delay_d = delay_q + DELAY_W'(1);
                end
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            delay_q <= '0;
        end else begin
            acc_q   <= acc_d;
            delay_q <= delay_d;
        end
    end

    assign delay = delay_q;

endmodule

// File: rtl/scanline_delay_sequencer.sv
// Scanline sequencer: starts the term calculator, consumes one term vector per scanpoint
// and presents the per-element sample delays to the beamforming sample fetch.
module scanline_delay_sequencer
    import scan_pkg::*;
#(
    parameter int DW_INTEGER   = DW_INTEGER_DEF,
    parameter int DW_FRACTION  = DW_FRACTION_DEF,
    parameter int DW_INPUT     = 8,
    parameter int DW_ANGLE     = 8,
    parameter int NUM_ELEMENTS = 64,
    parameter int DW_DELAY     = DW_DELAY_DEF,
    parameter int DW_POINTS    = 12,
    localparam int TERM_WIDTH  = DW_INTEGER + DW_FRACTION - 3,
    localparam int FRAC_BITS   = DW_FRACTION - 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [DW_INPUT-1:0]                         r_0_in,
    input  logic [DW_ANGLE-1:0]                         angle_in,
    input  logic [DW_POINTS-1:0]                        num_points,
    output logic                                        configure,
    output logic [DW_INPUT-1:0]                         r_0,
    output logic [DW_ANGLE-1:0]                         angle,
    input  logic signed [NUM_ELEMENTS-1:0][TERM_WIDTH-1:0] output_terms,
    input  logic                                        ready,
    input  logic                                        done_configuring,
    output logic                                        ack,
    output logic                                        final_scanpoint,
    output logic [NUM_ELEMENTS-1:0][DW_DELAY-1:0]       delay_idx,
    output logic                                        delay_valid,
    input  logic                                        delay_ready,
    output logic [DW_POINTS-1:0]                        point_idx,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        overflow,
    output state_t                                      fsm_state
);

    // Handshakes: term side consumes a vector in the cycle after ready is seen in
    // WAIT_TERMS (ack pulse); delay side holds delay_valid and data until delay_ready.
    state_t                state_q, state_d;
    logic [DW_INPUT-1:0]   r_0_q, r_0_d;
    logic [DW_ANGLE-1:0]   angle_q, angle_d;
    logic [DW_POINTS-1:0]  num_points_q, num_points_d;
    logic [DW_POINTS-1:0]  point_idx_q, point_idx_d;
    logic                  overflow_q, overflow_d;
    logic                  clear_acc, update_acc, last_point;
    logic [NUM_ELEMENTS-1:0] sat_vec;

    assign last_point = (point_idx_q == num_points_q - DW_POINTS'(1));

    always_comb begin
        state_d      = state_q;
        r_0_d        = r_0_q;
        angle_d      = angle_q;
        num_points_d = num_points_q;
        point_idx_d  = point_idx_q;
        overflow_d   = overflow_q | (|sat_vec);
        clear_acc    = 1'b0;
        update_acc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (num_points != '0)) begin
                    state_d      = CONFIG;
                    r_0_d        = r_0_in;
                    angle_d      = angle_in;
                    num_points_d = num_points;
                end
            end
            CONFIG: begin
                clear_acc   = 1'b1;
                point_idx_d = '0;
                overflow_d  = 1'b0;
                state_d     = WAIT_TERMS;
            end
            WAIT_TERMS: begin
                // The first vector is only trusted once the calculator reports it configured.
                if (ready && ((point_idx_q != '0) || done_configuring)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                update_acc = 1'b1;
                state_d    = PRESENT;
            end
            PRESENT: begin
                if (delay_ready) begin
                    if (last_point) begin
                        state_d = DONE;
                    end else begin
                        point_idx_d = point_idx_q + DW_POINTS'(1);
                        state_d     = WAIT_TERMS;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            r_0_q        <= '0;
            angle_q      <= '0;
            num_points_q <= '0;
            point_idx_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_0_q        <= r_0_d;
            angle_q      <= angle_d;
            num_points_q <= num_points_d;
            point_idx_q  <= point_idx_d;
            overflow_q   <= overflow_d;
        end
    end

    for (genvar n = 0; n < NUM_ELEMENTS; n++) begin : g_elem
        element_delay_tracker #(
            .TERM_W   (TERM_WIDTH),
            .DELAY_W  (DW_DELAY),
            .FRAC_OUT (FRAC_BITS)
        ) u_tracker (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear_acc),
            .update (update_acc),
            .term   (output_terms[n]),
            .delay  (delay_idx[n]),
            .sat    (sat_vec[n])
        );
    end

    assign configure       = (state_q == CONFIG);
    assign ack             = (state_q == UPDATE);
    assign final_scanpoint = (state_q == UPDATE) && last_point;
    assign delay_valid     = (state_q == PRESENT);
    assign done            = (state_q == DONE);
    assign busy            = (state_q != IDLE);
    assign r_0             = r_0_q;
    assign angle           = angle_q;
    assign point_idx       = point_idx_q;
    assign overflow        = overflow_q;
    assign fsm_state       = state_q;

endmodule

// File: tb/tb_scanline_delay_sequencer.sv
// Bench for scanline_delay_sequencer: a default-width instance and a 2-bit-delay instance
// run in lockstep on shared stimulus; a monitor scores every delay vector and ack.
module tb_scanline_delay_sequencer;
    import scan_pkg::*;

    localparam int NE  = 64;
    localparam int TW  = 21;
    localparam int DW  = 12;
    localparam int DWS = 2;
    localparam int PW  = 12;
    localparam int EW  = 36;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [7:0] r_0_in, angle_in, cur_r0;
    logic [PW-1:0] num_points;
    logic signed [NE-1:0][TW-1:0] output_terms;
    logic ready, done_configuring, delay_ready;

    logic a_configure, a_ack, a_final, a_valid, a_busy, a_done, a_ovf;
    logic [7:0] a_r_0, a_angle;
    logic [NE-1:0][DW-1:0] a_delay;
    logic [PW-1:0] a_point;
    state_t a_state;

    logic b_configure, b_ack, b_final, b_valid, b_busy, b_done, b_ovf;
    logic [7:0] b_r_0, b_angle;
    logic [NE-1:0][DWS-1:0] b_delay;
    logic [PW-1:0] b_point;
    state_t b_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    logic [0:0]    ack_q[$];
    logic [EW-1:0] e;
    logic [0:0]    f;
    logic          done_prev = 1'b0;

    always #5 clk = ~clk;

    scanline_delay_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start), .r_0_in(r_0_in), .angle_in(angle_in),
        .num_points(num_points), .configure(a_configure), .r_0(a_r_0), .angle(a_angle),
        .output_terms(output_terms), .ready(ready), .done_configuring(done_configuring),
        .ack(a_ack), .final_scanpoint(a_final), .delay_idx(a_delay), .delay_valid(a_valid),
        .delay_ready(delay_ready), .point_idx(a_point), .busy(a_busy), .done(a_done),
        .overflow(a_ovf), .fsm_state(a_state)
    );

    scanline_delay_sequencer #(.DW_DELAY(DWS)) dut_b (
        .clk(clk), .rst(rst), .start(start), .r_0_in(r_0_in), .angle_in(angle_in),
        .num_points(num_points), .configure(b_configure), .r_0(b_r_0), .angle(b_angle),
        .output_terms(output_terms), .ready(ready), .done_configuring(done_configuring),
        .ack(b_ack), .final_scanpoint(b_final), .delay_idx(b_delay), .delay_valid(b_valid),
        .delay_ready(delay_ready), .point_idx(b_point), .busy(b_busy), .done(b_done),
        .overflow(b_ovf), .fsm_state(b_state)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int pt, input int da, input int db);
        exp_q.push_back({12'(pt), 12'(da), 12'(db)});
    endtask

    // Monitor: scores each accepted delay vector and each ack against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_valid && delay_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_delay_vector", 1, 0);
                end else begin
                    longint act_a, act_b;
                    e = exp_q.pop_front();
                    act_a = e[23:12];
                    act_b = e[11:0];
                    for (int n = 0; n < NE; n++) begin
                        if (a_delay[n] != e[23:12]) act_a = a_delay[n];
                        if (12'(b_delay[n]) != e[11:0]) act_b = b_delay[n];
                    end
                    chk("point_idx", a_point, e[35:24]);
                    chk("delay_idx_a", act_a, e[23:12]);
                    chk("delay_idx_b", act_b, e[11:0]);
                    chk("lockstep_valid_b", b_valid, 1);
                end
            end
            if (a_ack) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    f = ack_q.pop_front();
                    chk("final_scanpoint_a", a_final, f);
                    chk("final_scanpoint_b", b_final, f);
                end
            end
            if (done_prev) chk("done_pulse_width", a_done, 0);
            done_prev = a_done;
        end
    end

    task automatic set_terms(input int t);
        for (int n = 0; n < NE; n++) output_terms[n] = TW'(t);
    endtask

    task automatic start_scan(input int np, input int t, input logic [7:0] r0, input logic [7:0] ang);
        @(posedge clk); #1;
        set_terms(t);
        r_0_in = r0; cur_r0 = r0; angle_in = ang; num_points = PW'(np);
        start = 1'b1; done_configuring = 1'b0; ready = 1'b1; delay_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("configure_pulse", a_configure, 1);
        chk("r_0_latched", a_r_0, r0);
        chk("angle_latched", a_angle, ang);
        chk("busy_in_config", a_busy, 1);
        @(negedge clk);
        chk("configure_one_cycle", a_configure, 0);
        chk("overflow_cleared_a", a_ovf, 0);
        chk("overflow_cleared_b", b_ovf, 0);
        repeat (2) begin
            @(negedge clk);
            chk("no_ack_before_done_configuring", a_ack, 0);
        end
        @(posedge clk); #1;
        done_configuring = 1'b1;
    endtask

    task automatic wait_valid();
        int c;
        c = 0;
        @(negedge clk);
        while (!a_valid && c < 50) begin
            c++;
            @(negedge clk);
        end
        chk("delay_valid_latency", c, 2);
    endtask

    task automatic serve_point(input int p, input bit stall);
        logic [DW-1:0] held;
        wait_valid();
        if (stall) begin
            held = a_delay[0];
            @(posedge clk); #1;
            start = 1'b1; r_0_in = ~cur_r0; num_points = PW'(1);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk("stall_valid_held", a_valid, 1);
                chk("stall_no_ack", a_ack, 0);
                chk("stall_point_idx", a_point, p);
                chk("stall_delay_stable", a_delay[0], held);
                chk("stall_r_0_held", a_r_0, cur_r0);
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        delay_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        delay_ready = 1'b0;
    endtask

    task automatic finish_scan(input int ova, input int ovb);
        @(negedge clk);
        chk("done_pulse_a", a_done, 1);
        chk("done_pulse_b", b_done, 1);
        chk("overflow_a", a_ovf, ova);
        chk("overflow_b", b_ovf, ovb);
        @(negedge clk);
        chk("idle_after_done", a_busy, 0);
        chk("overflow_sticky_b", b_ovf, ovb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; r_0_in = '0; angle_in = '0; num_points = '0; cur_r0 = '0;
        ready = 1'b0; done_configuring = 1'b0; delay_ready = 1'b0;
        set_terms(0);
        repeat (2) @(negedge clk);
        chk("reset_state", a_state, IDLE);
        chk("reset_busy", a_busy, 0);
        chk("reset_valid", a_valid, 0);
        chk("reset_ack", a_ack, 0);
        chk("reset_configure", a_configure, 0);
        chk("reset_delay0", a_delay[0], 0);
        chk("reset_point_idx", a_point, 0);
        chk("reset_overflow", a_ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Terms of 1.0: delays 1,1,1,2.
        push_exp(0, 1, 1); push_exp(1, 1, 1); push_exp(2, 1, 1); push_exp(3, 2, 2);
        ack_q.push_back(0); ack_q.push_back(0); ack_q.push_back(0); ack_q.push_back(1);
        start_scan(4, 16, 8'h21, 8'h5a);
        for (int p = 0; p < 4; p++) serve_point(p, 1'b0);
        finish_scan(0, 0);

        // Negative terms never decrement.
        push_exp(0, 0, 0); push_exp(1, 0, 0); push_exp(2, 0, 0);
        ack_q.push_back(0); ack_q.push_back(0); ack_q.push_back(1);
        start_scan(3, -8, 8'h33, 8'h01);
        for (int p = 0; p < 3; p++) serve_point(p, 1'b0);
        finish_scan(0, 0);

        // Downstream stall on point 1; a start pulse during it is ignored.
        push_exp(0, 1, 1); push_exp(1, 1, 1); push_exp(2, 1, 1); push_exp(3, 2, 2);
        ack_q.push_back(0); ack_q.push_back(0); ack_q.push_back(0); ack_q.push_back(1);
        start_scan(4, 16, 8'h44, 8'h80);
        for (int p = 0; p < 4; p++) serve_point(p, p == 1);
        finish_scan(0, 0);

        // Single-point scanline.
        push_exp(0, 1, 1);
        ack_q.push_back(1);
        start_scan(1, 16, 8'h55, 8'h7f);
        serve_point(0, 1'b0);
        finish_scan(0, 0);

        // Large terms: the 2-bit instance saturates at 3 and flags overflow.
        push_exp(0, 1, 1); push_exp(1, 2, 2); push_exp(2, 3, 3); push_exp(3, 4, 3);
        ack_q.push_back(0); ack_q.push_back(0); ack_q.push_back(0); ack_q.push_back(1);
        start_scan(4, 4096, 8'h66, 8'h10);
        for (int p = 0; p < 4; p++) serve_point(p, 1'b0);
        finish_scan(0, 1);

        // Next scanline clears overflow and the counters.
        push_exp(0, 1, 1);
        ack_q.push_back(1);
        start_scan(1, 16, 8'h77, 8'h20);
        serve_point(0, 1'b0);
        finish_scan(0, 0);

        // num_points == 0 is ignored.
        @(posedge clk); #1;
        start = 1'b1; num_points = '0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("zero_points_ignored", a_busy, 0);
        end

        // Reset while presenting point 1, then a clean scanline.
        push_exp(0, 1, 1);
        ack_q.push_back(0); ack_q.push_back(0);
        start_scan(4, 16, 8'h88, 8'h30);
        serve_point(0, 1'b0);
        wait_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", a_valid, 0);
        chk("rst_mid_busy", a_busy, 0);
        chk("rst_mid_point_idx", a_point, 0);
        chk("rst_mid_delay0", a_delay[0], 0);
        chk("rst_mid_r_0", a_r_0, 0);
        chk("rst_mid_state", a_state, IDLE);
        chk("rst_mid_valid_b", b_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_exp(0, 1, 1); push_exp(1, 1, 1);
        ack_q.push_back(0); ack_q.push_back(1);
        start_scan(2, 16, 8'h99, 8'h40);
        serve_point(0, 1'b0);
        serve_point(1, 1'b0);
        finish_scan(0, 0);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
